// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage RV32 core.
// Stall/flush enables, EX forwarding selects, dmem wait FSM, perf counters.
module pipe_hazard_ctrl #(
    parameter int          AW      = 5,
    parameter int          CW      = 32,
    parameter int          TIMEOUT = 255,
    parameter logic [1:0]  WB_LOAD = 2'b01
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rs1_d,
    input  logic [AW-1:0] rs2_d,
    input  logic          use_rs1_d,
    input  logic          use_rs2_d,
    input  logic [AW-1:0] rs1_e,
    input  logic [AW-1:0] rs2_e,
    input  logic [AW-1:0] rd_e,
    input  logic [AW-1:0] rd_m,
    input  logic [AW-1:0] rd_w,
    input  logic          RegWEnE,
    input  logic          RegWEnM,
    input  logic          RegWEnW,
    input  logic [1:0]    WBSelE,
    input  logic          PCSelE,
    input  logic          dmem_req_m,
    input  logic          dmem_ack,
    output logic          stall_f,
    output logic          stall_d,
    output logic          stall_e,
    output logic          stall_m,
    output logic          flush_d,
    output logic          flush_e,
    output logic [1:0]    fwd_a_e,
    output logic [1:0]    fwd_b_e,
    output logic          mem_err,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, WAIT, ERR} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_wait_cnt;
    logic [15:0]   w_wait_nxt;
    logic [CW-1:0] r_stall_cnt;
    logic [CW-1:0] r_flush_cnt;
    logic          w_err;
    logic          w_hold;
    logic          w_freeze;
    logic          w_load_e;
    logic          w_lu;
    logic          w_br;

    assign w_err    = (r_state == ERR);
    assign w_hold   = dmem_req_m & ~dmem_ack & ~w_err;
    assign w_freeze = w_hold | w_err;
    assign w_load_e = RegWEnE & (WBSelE == WB_LOAD) & (rd_e != '0);
    assign w_br     = ~w_freeze & PCSelE;
    assign w_lu     = ~w_freeze & ~PCSelE & w_load_e &
                      ((use_rs1_d & (rs1_d == rd_e)) |
                       (use_rs2_d & (rs2_d == rd_e)));

    // dmem wait state register and consecutive-wait counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
        end
    end

    // dmem wait sequencing; a withdrawn request also returns to RUN
    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait_cnt;
        unique case (r_state)
            RUN: begin
                if (w_hold) begin
                    w_state_nxt = WAIT;
                    w_wait_nxt  = 16'd1;
                end
            end
            WAIT: begin
                if (dmem_ack || !w_hold) begin
                    w_state_nxt = RUN;
                    w_wait_nxt  = '0;
                end else if (r_wait_cnt == 16'(TIMEOUT)) begin
                    w_state_nxt = ERR;
                end else begin
                    w_wait_nxt  = r_wait_cnt + 16'd1;
                end
            end
            ERR: begin
                w_state_nxt = ERR;
            end
            default: begin
                w_state_nxt = RUN;
                w_wait_nxt  = '0;
            end
        endcase
    end

    // stall/flush enables: memory freeze, then branch, then load-use
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (!rst) begin
            if (w_freeze) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                stall_e = 1'b1;
                stall_m = 1'b1;
            end else if (w_br) begin
                flush_d = 1'b1;
                flush_e = 1'b1;
            end else if (w_lu) begin
                stall_f = 1'b1;
                stall_d = 1'b1;
                flush_e = 1'b1;
            end
        end
    end

    // EX operand forwarding, M result preferred over W
    always_comb begin
        fwd_a_e = 2'b00;
        fwd_b_e = 2'b00;
        if (!rst) begin
            if (RegWEnM && rd_m != '0 && rd_m == rs1_e)
                fwd_a_e = 2'b10;
            else if (RegWEnW && rd_w != '0 && rd_w == rs1_e)
                fwd_a_e = 2'b01;
            if (RegWEnM && rd_m != '0 && rd_m == rs2_e)
                fwd_b_e = 2'b10;
            else if (RegWEnW && rd_w != '0 && rd_w == rs2_e)
                fwd_b_e = 2'b01;
        end
    end

    // saturating stall and branch-flush cycle counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_d && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CW'(1);
            if (w_br && r_flush_cnt != '1)
                r_flush_cnt <= r_flush_cnt + CW'(1);
        end
    end

    assign mem_err   = w_err;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: directed plan then random traffic.
// Reference model tracks error flag, held-run length and counter values.
module tb_pipe_hazard_ctrl;

    localparam int AW  = 5;
    localparam int CW  = 4;
    localparam int TO  = 4;
    localparam int MAX = 15;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          use_rs1_d, use_rs2_d;
    logic          RegWEnE, RegWEnM, RegWEnW;
    logic [1:0]    WBSelE;
    logic          PCSelE, dmem_req_m, dmem_ack;
    logic          stall_f, stall_d, stall_e, stall_m;
    logic          flush_d, flush_e, mem_err;
    logic [1:0]    fwd_a_e, fwd_b_e;
    logic [CW-1:0] stall_cnt, flush_cnt;

    typedef struct {
        int sf; int sd; int se; int sm;
        int fd; int fe; int fa; int fb;
        int err; int sc; int fc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   done = 0;

    int   m_err = 0;
    int   m_run = 0;
    int   m_sc  = 0;
    int   m_fc  = 0;

    pipe_hazard_ctrl #(.AW(AW), .CW(CW), .TIMEOUT(TO), .WB_LOAD(2'b01)) dut (
        .clk(clk), .rst(rst),
        .rs1_d(rs1_d), .rs2_d(rs2_d),
        .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
        .RegWEnE(RegWEnE), .RegWEnM(RegWEnM), .RegWEnW(RegWEnW),
        .WBSelE(WBSelE), .PCSelE(PCSelE),
        .dmem_req_m(dmem_req_m), .dmem_ack(dmem_ack),
        .stall_f(stall_f), .stall_d(stall_d),
        .stall_e(stall_e), .stall_m(stall_m),
        .flush_d(flush_d), .flush_e(flush_e),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .mem_err(mem_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fwd(input logic [AW-1:0] rs);
        if (RegWEnM && rd_m != 0 && rd_m == rs) return 2;
        if (RegWEnW && rd_w != 0 && rd_w == rs) return 1;
        return 0;
    endfunction

    task automatic clr();
        rst = 0;
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
        rd_e = 0; rd_m = 0; rd_w = 0;
        use_rs1_d = 0; use_rs2_d = 0;
        RegWEnE = 0; RegWEnM = 0; RegWEnW = 0;
        WBSelE = 0; PCSelE = 0; dmem_req_m = 0; dmem_ack = 0;
    endtask

    task automatic nx();
        @(negedge clk);
        clr();
    endtask

    // expected response for the inputs now applied, then advance the model
    task automatic apply();
        exp_t e;
        bit held, frz, br, ld, lu;
        e.sf = 0; e.sd = 0; e.se = 0; e.sm = 0;
        e.fd = 0; e.fe = 0; e.fa = 0; e.fb = 0;
        e.err = 0; e.sc = 0; e.fc = 0;
        if (rst) begin
            m_err = 0; m_run = 0; m_sc = 0; m_fc = 0;
            q.push_back(e);
            return;
        end
        held = (m_err == 0) && dmem_req_m && !dmem_ack;
        frz  = (m_err != 0) || held;
        br   = !frz && PCSelE;
        ld   = RegWEnE && WBSelE == 2'b01 && rd_e != 0;
        lu   = !frz && !PCSelE && ld &&
               ((use_rs1_d && rs1_d == rd_e) || (use_rs2_d && rs2_d == rd_e));
        e.sf = int'(frz || lu);
        e.sd = int'(frz || lu);
        e.se = int'(frz);
        e.sm = int'(frz);
        e.fd = int'(br);
        e.fe = int'(br || lu);
        e.fa = fwd(rs1_e);
        e.fb = fwd(rs2_e);
        e.err = m_err;
        e.sc = m_sc;
        e.fc = m_fc;
        q.push_back(e);
        if (e.sd != 0 && m_sc < MAX) m_sc++;
        if (br && m_fc < MAX) m_fc++;
        if (m_err == 0) begin
            if (held) begin
                m_run++;
                if (m_run > TO) m_err = 1;
            end else begin
                m_run = 0;
            end
        end
    endtask

    task automatic chk(input string nm, input int act, input int ex);
        checks++;
        if (act != ex) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, ex);
        end
    endtask

    task automatic set_lu();
        WBSelE = 2'b01; RegWEnE = 1; rd_e = 5; rs1_d = 5; use_rs1_d = 1;
    endtask

    // monitor: compare DUT outputs against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stall_f", int'(stall_f), e.sf);
                chk("stall_d", int'(stall_d), e.sd);
                chk("stall_e", int'(stall_e), e.se);
                chk("stall_m", int'(stall_m), e.sm);
                chk("flush_d", int'(flush_d), e.fd);
                chk("flush_e", int'(flush_e), e.fe);
                chk("fwd_a_e", int'(fwd_a_e), e.fa);
                chk("fwd_b_e", int'(fwd_b_e), e.fb);
                chk("mem_err", int'(mem_err), e.err);
                chk("stall_cnt", int'(stall_cnt), e.sc);
                chk("flush_cnt", int'(flush_cnt), e.fc);
            end
        end
    end

    // stimulus
    initial begin
        clr();
        rst = 1;
        repeat (2) begin nx(); rst = 1; apply(); end
        nx(); set_lu(); apply();
        nx(); apply();
        nx(); set_lu(); rd_e = 0; rs1_d = 0; apply();
        nx(); set_lu(); PCSelE = 1; apply();
        nx(); apply();
        nx(); rd_m = 7; rd_w = 7; rs1_e = 7; rs2_e = 3;
        RegWEnM = 1; RegWEnW = 1; apply();
        nx(); rd_m = 7; rd_w = 7; rs1_e = 7; rs2_e = 3;
        RegWEnW = 1; apply();
        nx(); rs1_e = 0; RegWEnM = 1; RegWEnW = 1; apply();
        nx(); dmem_req_m = 1; dmem_ack = 1; apply();
        repeat (3) begin
            nx(); dmem_req_m = 1; PCSelE = 1; set_lu(); apply();
        end
        nx(); dmem_req_m = 1; dmem_ack = 1; PCSelE = 1; apply();
        nx(); apply();
        repeat (8) begin nx(); dmem_req_m = 1; apply(); end
        nx(); PCSelE = 1; apply();
        nx(); rst = 1; apply();
        nx(); apply();
        for (int i = 0; i < 3000; i++) begin
            nx();
            rst        = ($urandom_range(0, 99) < 2);
            rs1_d      = AW'($urandom_range(0, 3));
            rs2_d      = AW'($urandom_range(0, 3));
            rs1_e      = AW'($urandom_range(0, 3));
            rs2_e      = AW'($urandom_range(0, 3));
            rd_e       = AW'($urandom_range(0, 3));
            rd_m       = AW'($urandom_range(0, 3));
            rd_w       = AW'($urandom_range(0, 3));
            use_rs1_d  = 1'($urandom_range(0, 1));
            use_rs2_d  = 1'($urandom_range(0, 1));
            RegWEnE    = 1'($urandom_range(0, 1));
            RegWEnM    = 1'($urandom_range(0, 1));
            RegWEnW    = 1'($urandom_range(0, 1));
            WBSelE     = 2'($urandom_range(0, 3));
            PCSelE     = ($urandom_range(0, 9) < 2);
            dmem_req_m = ($urandom_range(0, 9) < 5);
            dmem_ack   = ($urandom_range(0, 9) < 4);
            apply();
        end
        nx();
        done = 1;
    end

    // end of run and overall time bound
    initial begin
        fork
            wait (done);
            #500000;
        join_any
        disable fork;
        #5;
        checks++;
        if (!done || q.size() != 0) begin
            errors++;
            $display("FAIL drain done=%0d pending=%0d expected done=1 pending=0",
                     done, q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline controller for the 5-stage RV32 core. It generates stall and flush enables for the IF/ID, ID/EX and EX/MEM pipeline registers, and forwarding selects for the EX-stage operand muxes. It sequences data-memory wait states through a small FSM with a timeout, and keeps saturating stall and flush performance counters. It sits beside the ID/EX control register and consumes the E/M/W-stage copies of RegWEn, WBSel and PCSel.

Parameters:
AW, 5, register-index width.
CW, 32, performance counter width.
TIMEOUT, 255, maximum consecutive dmem wait cycles before error (1..2^16-1).
WB_LOAD, 2'b01, WBSel encoding that marks a load (write-back from memory).

Ports:
clk  input  1  clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
rs1_d  input  AW  rs1 index of the instruction in D.
rs2_d  input  AW  rs2 index in D.
use_rs1_d  input  1  D instruction reads rs1.
use_rs2_d  input  1  D instruction reads rs2.
rs1_e  input  AW  rs1 index in E.
rs2_e  input  AW  rs2 index in E.
rd_e  input  AW  destination index in E.
rd_m  input  AW  destination index in M.
rd_w  input  AW  destination index in W.
RegWEnE  input  1  E-stage register write enable.
RegWEnM  input  1  M-stage register write enable.
RegWEnW  input  1  W-stage register write enable.
WBSelE  input  2  E-stage write-back select.
PCSelE  input  1  branch/jump taken, resolved in E.
dmem_req_m  input  1  M-stage data-memory access active.
dmem_ack  input  1  data memory completes this cycle.
stall_f  output  1  hold PC.
stall_d  output  1  hold IF/ID.
stall_e  output  1  hold ID/EX.
stall_m  output  1  hold EX/MEM.
flush_d  output  1  clear IF/ID to NOP.
flush_e  output  1  clear ID/EX to bubble.
fwd_a_e  output  2  operand A select: 00 regfile, 01 W, 10 M.
fwd_b_e  output  2  operand B select, same encoding.
mem_err  output  1  sticky dmem timeout error.
stall_cnt  output  CW  cycles with stall_d=1.
flush_cnt  output  CW  cycles with a branch flush.

Behaviour:
- FSM states: RUN, WAIT, ERR. Reset state is RUN. wait_cnt (16 bit) resets to 0.
- mem_hold = dmem_req_m & ~dmem_ack, evaluated combinationally in RUN and WAIT.
- A zero-wait ack (req and ack in the same cycle) causes no stall.
- RUN -> WAIT when mem_hold; wait_cnt <= 1.
- WAIT -> RUN when dmem_ack; wait_cnt <= 0.
- WAIT stays WAIT while mem_hold; wait_cnt increments.
- WAIT -> ERR when mem_hold and wait_cnt == TIMEOUT.
- ERR is held until rst.
- mem_hold or ERR: stall_f = stall_d = stall_e = stall_m = 1, flush_d = flush_e = 0. This takes absolute priority and also freezes branch and load-use handling.
- Otherwise, branch taken (PCSelE=1): flush_d = 1 and flush_e = 1, no stalls. The load-use check is ignored because D is squashed.
- Otherwise, load-use: load_e = RegWEnE & (WBSelE == WB_LOAD) & (rd_e != 0). Hazard when load_e and ((use_rs1_d & rs1_d == rd_e) | (use_rs2_d & rs2_d == rd_e)). Response: stall_f = stall_d = 1 and flush_e = 1 for exactly one cycle. The load advances to M, so the condition clears on the next cycle.
- All stall/flush outputs are combinational, settling in the same cycle as their inputs.
- Forwarding (combinational, active in every state): fwd_a_e = 10 if RegWEnM & rd_m != 0 & rd_m == rs1_e; else 01 if RegWEnW & rd_w != 0 & rd_w == rs1_e; else 00. fwd_b_e uses rs2_e. M has priority over W.
- mem_err = 1 exactly while in ERR (registered, from the state).
- stall_cnt increments on clk when stall_d = 1; flush_cnt increments when the branch-flush condition is active. Both saturate at all-ones and never wrap.
- While rst is high: all stall/flush/fwd outputs = 0, mem_err = 0, counters = 0, state = RUN. Reset asserted mid-WAIT aborts the wait immediately.

Test Plan:
- Load-use: WBSelE=01, RegWEnE=1, rd_e=5, rs1_d=5, use_rs1_d=1 -> one cycle of stall_f=stall_d=flush_e=1; stall_cnt=1.
- Load to x0: same as above but rd_e=0 and rs1_d=0 -> no stall, no flush.
- Branch plus load-use together: PCSelE=1 with the load-use condition above -> flush_d=flush_e=1, stall_d=0; flush_cnt increments by 1.
- Forwarding priority: rd_m=rd_w=rs1_e=7, RegWEnM=RegWEnW=1 -> fwd_a_e=10; then RegWEnM=0 -> fwd_a_e=01; rs2_e=3 with no match -> fwd_b_e=00.
- Memory wait: dmem_req_m=1, ack low for 3 cycles, then high -> all four stalls=1 for 3 cycles, FSM RUN->WAIT->RUN, stalls drop in the ack cycle; a simultaneous PCSelE=1 gives no flush until the ack.
- Timeout: TIMEOUT=4, ack never arrives -> ERR entered after the 5th held cycle, mem_err=1 and stalls stay 1 indefinitely; rst pulse -> mem_err=0, stall_cnt=0, state=RUN.
